ysyx_23060191_csr_seq: RTL and testbench

Sequencer that drives the CSR register file's port set (read/write address, write data, write enable, ecall trap entry) on behalf of the execute stage. It turns one decoded CSR-class instruction (Zicsr read-modify-write, ECALL, MRET) into a fixed multi-cycle access sequence. It returns rd data or a PC redirect to the core, and sits between IDU/EXU and the CSR file.

---
 rtl/ysyx_23060191_csr_seq_pkg.sv | 32 +++
 rtl/ysyx_23060191_csr_seq_csr_alu.sv | 17 +
 rtl/ysyx_23060191_csr_seq.sv | 98 +++++++++
 tb/tb_ysyx_23060191_csr_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060191_csr_seq_pkg.sv
// ysyx_23060191_csr_seq_pkg: shared datapath width, CSR addresses, op and state encodings
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef MSTATUS
`define MSTATUS 12'h300
`endif
`ifndef MTVEC
`define MTVEC 12'h305
`endif
`ifndef MEPC
`define MEPC 12'h341
`endif
`ifndef MCAUSE
`define MCAUSE 12'h342
`endif

package ysyx_23060191_csr_seq_pkg;
  localparam logic [2:0] CSR_OP_RW    = 3'd0;
  localparam logic [2:0] CSR_OP_RS    = 3'd1;
  localparam logic [2:0] CSR_OP_RC    = 3'd2;
  localparam logic [2:0] CSR_OP_ECALL = 3'd3;
  localparam logic [2:0] CSR_OP_MRET  = 3'd4;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_TRAP  = 3'd3;
  localparam logic [2:0] ST_REDIR = 3'd4;
  function automatic logic is_rmw(input logic [2:0] op);
    return op == CSR_OP_RW || op == CSR_OP_RS || op == CSR_OP_RC;
  endfunction
endpackage

// File: rtl/ysyx_23060191_csr_seq_csr_alu.sv
// ysyx_23060191_csr_alu: Zicsr read-modify-write merge and write-suppress decision
module ysyx_23060191_csr_alu
  import ysyx_23060191_csr_seq_pkg::*;
(
  input  logic [2:0]            op,
  input  logic [`CPU_WIDTH-1:0] old,
  input  logic [`CPU_WIDTH-1:0] src,
  input  logic                  src_zero,
  output logic [`CPU_WIDTH-1:0] wdata,
  output logic                  no_wr
);
  // set/clear with a zero operand must not write, so read-only CSRs stay quiet
  always_comb begin
    wdata = op == CSR_OP_RS ? old | src : op == CSR_OP_RC ? old & ~src : src;
    no_wr = !is_rmw(op) || (op != CSR_OP_RW && src_zero);
  end
endmodule

// File: rtl/ysyx_23060191_csr_seq.sv
// ysyx_23060191_csr_seq: turns one CSR-class instruction into a fixed CSR file access sequence
module ysyx_23060191_csr_seq
  import ysyx_23060191_csr_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [11:0]           req_csr_addr,
  input  logic [`CPU_WIDTH-1:0] req_src,
  input  logic                  req_src_zero,
  input  logic [`CPU_WIDTH-1:0] req_pc,
  input  logic [`CPU_WIDTH-1:0] req_a7,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [`CPU_WIDTH-1:0] resp_rd_data,
  output logic                  resp_illegal,
  output logic                  redirect_valid,
  output logic [`CPU_WIDTH-1:0] redirect_pc,
  output logic [11:0]           addr_rd_csr,
  input  logic [`CPU_WIDTH-1:0] data_rd_csr,
  output logic                  wr_en_csr,
  output logic [11:0]           addr_wr_csr,
  output logic [`CPU_WIDTH-1:0] data_wr_csr,
  output logic                  ecall_en,
  output logic [7:0]            ecall_NO,
  input  logic [`CPU_WIDTH-1:0] mtvec,
  input  logic [`CPU_WIDTH-1:0] mepc
);
  logic [2:0]            state, op_q;
  logic [11:0]           addr_q;
  logic [`CPU_WIDTH-1:0] src_q, pc_q, old_q, alu_wdata;
  logic                  zero_q, alu_no_wr;
  logic [7:0]            no_q;
  logic                  unused_a7;

  assign unused_a7 = ^req_a7[`CPU_WIDTH-1:8];

  ysyx_23060191_csr_alu u_alu (
    .op       (op_q),
    .old      (old_q),
    .src      (src_q),
    .src_zero (zero_q),
    .wdata    (alu_wdata),
    .no_wr    (alu_no_wr)
  );

  // sequence state and the request latches; old value is captured in READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      addr_q <= '0;
      src_q  <= '0;
      zero_q <= 1'b0;
      pc_q   <= '0;
      no_q   <= '0;
      old_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          op_q   <= req_op;
          addr_q <= req_csr_addr;
          src_q  <= req_src;
          zero_q <= req_src_zero;
          pc_q   <= req_pc;
          no_q   <= req_a7[7:0];
          old_q  <= '0;
          state  <= is_rmw(req_op) ? ST_READ : req_op == CSR_OP_ECALL ? ST_TRAP :
                    req_op == CSR_OP_MRET ? ST_REDIR : ST_WRITE;
        end
        ST_READ: begin
          old_q <= data_rd_csr;
          state <= flush ? ST_IDLE : ST_WRITE;
        end
        ST_TRAP: state <= ST_REDIR;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // all strobes decode straight from state so an async reset kills them at once
  always_comb begin
    req_ready      = state == ST_IDLE;
    resp_valid     = state == ST_WRITE;
    resp_rd_data   = old_q;
    resp_illegal   = state == ST_WRITE && !is_rmw(op_q);
    wr_en_csr      = state == ST_WRITE && !alu_no_wr;
    addr_rd_csr    = addr_q;
    addr_wr_csr    = addr_q;
    ecall_en       = state == ST_TRAP;
    data_wr_csr    = state == ST_TRAP ? pc_q : alu_wdata;
    ecall_NO       = no_q;
    redirect_valid = state == ST_REDIR;
    redirect_pc    = state != ST_REDIR ? '0 : op_q == CSR_OP_ECALL ? mtvec : mepc;
  end
endmodule

// File: tb/tb_ysyx_23060191_csr_seq.sv
// tb_ysyx_23060191_csr_seq: directed checks of the CSR sequencer against a small CSR file model
module tb_ysyx_23060191_csr_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_src_zero = 1'b0, flush = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [11:0] req_csr_addr = 12'h0, addr_rd_csr, addr_wr_csr;
  logic [31:0] req_src = 32'h0, req_pc = 32'h0, req_a7 = 32'h0;
  logic        resp_valid, resp_illegal, redirect_valid, wr_en_csr, ecall_en;
  logic [31:0] resp_rd_data, redirect_pc, data_rd_csr, data_wr_csr;
  logic [7:0]  ecall_NO;
  logic [31:0] mtvec = 32'h80000000, mepc = 32'h0, mstatus = 32'h1800, mcause = 32'h0;
  int          n_checks = 0, n_fail = 0;
  int          wr_cnt = 0, ecall_cnt = 0, redir_cnt = 0, resp_cnt = 0;
  int          w0, r0, d0;

  ysyx_23060191_csr_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr_addr(req_csr_addr), .req_src(req_src), .req_src_zero(req_src_zero), .req_pc(req_pc),
    .req_a7(req_a7), .flush(flush), .resp_valid(resp_valid), .resp_rd_data(resp_rd_data),
    .resp_illegal(resp_illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .addr_rd_csr(addr_rd_csr), .data_rd_csr(data_rd_csr), .wr_en_csr(wr_en_csr),
    .addr_wr_csr(addr_wr_csr), .data_wr_csr(data_wr_csr), .ecall_en(ecall_en),
    .ecall_NO(ecall_NO), .mtvec(mtvec), .mepc(mepc)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (addr_rd_csr)
      12'h300: data_rd_csr = mstatus;
      12'h305: data_rd_csr = mtvec;
      12'h341: data_rd_csr = mepc;
      12'h342: data_rd_csr = mcause;
      default: data_rd_csr = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (wr_en_csr) begin
      wr_cnt <= wr_cnt + 1;
      case (addr_wr_csr)
        12'h300: mstatus <= data_wr_csr;
        12'h305: mtvec   <= data_wr_csr;
        12'h341: mepc    <= data_wr_csr;
        12'h342: mcause  <= data_wr_csr;
        default: ;
      endcase
    end
    if (ecall_en) begin
      ecall_cnt <= ecall_cnt + 1;
      mepc      <= data_wr_csr;
      mcause    <= {24'h0, ecall_NO};
    end
    if (redirect_valid) redir_cnt <= redir_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  always @(negedge clk) if (rst_n) begin
    n_checks++;
    assert (!(wr_en_csr && ecall_en)) else begin
      n_fail++;
      $error("FAIL strobe_overlap: observed wr_en=%0b ecall_en=%0b expected not both", wr_en_csr, ecall_en);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                      input logic zero, input logic [31:0] pc, input logic [31:0] a7);
    @(negedge clk);
    chk("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_op = op; req_csr_addr = addr; req_src = src;
    req_src_zero = zero; req_pc = pc; req_a7 = a7;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_strobes", {27'h0, resp_valid, wr_en_csr, ecall_en, redirect_valid, resp_illegal}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_data_wr", data_wr_csr, 32'h0);
    chk("rst_addr_wr", {20'h0, addr_wr_csr}, 32'h0);
    rst_n = 1'b1;

    send(3'd0, 12'h305, 32'h80000100, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rw_read_addr", {20'h0, addr_rd_csr}, 32'h305);
    chk("rw_read_busy", {29'h0, req_ready, wr_en_csr, resp_valid}, 32'h0);
    @(negedge clk);
    chk("rw_resp", {30'h0, resp_valid, wr_en_csr}, 32'h3);
    chk("rw_old", resp_rd_data, 32'h80000000);
    chk("rw_wdata", data_wr_csr, 32'h80000100);
    chk("rw_waddr", {20'h0, addr_wr_csr}, 32'h305);
    chk("rw_illegal", {31'h0, resp_illegal}, 32'h0);
    @(negedge clk);
    chk("rw_ready_t3", {31'h0, req_ready}, 32'h1);
    chk("rw_mtvec_after", mtvec, 32'h80000100);

    w0 = wr_cnt;
    send(3'd1, 12'h300, 32'h0, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rs0_resp", {31'h0, resp_valid}, 32'h1);
    chk("rs0_old", resp_rd_data, 32'h1800);
    @(negedge clk);
    chk("rs0_no_write", wr_cnt, w0);

    send(3'd0, 12'h342, 32'hFF, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    send(3'd2, 12'h342, 32'h0F, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rc_old", resp_rd_data, 32'hFF);
    chk("rc_wen", {31'h0, wr_en_csr}, 32'h1);
    chk("rc_wdata", data_wr_csr, 32'hF0);
    send(3'd1, 12'h342, 32'h300, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rs_wdata", data_wr_csr, 32'h3F0);
    send(3'd0, 12'h305, 32'h80001000, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    send(3'd3, 12'h0, 32'h0, 1'b0, 32'h80000040, 32'hABCD000B);
    @(negedge clk);
    chk("ecall_en", {30'h0, ecall_en, wr_en_csr}, 32'h2);
    chk("ecall_pc", data_wr_csr, 32'h80000040);
    chk("ecall_no", {24'h0, ecall_NO}, 32'h0B);
    chk("ecall_no_redirect", {31'h0, redirect_valid}, 32'h0);
    @(negedge clk);
    chk("ecall_redir", {30'h0, redirect_valid, ecall_en}, 32'h2);
    chk("ecall_target", redirect_pc, 32'h80001000);
    chk("ecall_mepc", mepc, 32'h80000040);
    chk("ecall_mcause", mcause, 32'h0B);

    send(3'd4, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mret_redir", {31'h0, redirect_valid}, 32'h1);
    chk("mret_target", redirect_pc, 32'h80000040);
    @(negedge clk);
    chk("mret_ready", {30'h0, req_ready, redirect_valid}, 32'h2);

    w0 = wr_cnt; r0 = resp_cnt;
    send(3'd0, 12'h305, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_read", {20'h0, addr_rd_csr}, 32'h305);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {29'h0, req_ready, resp_valid, wr_en_csr}, 32'h4);
    repeat (2) @(negedge clk);
    chk("flush_no_resp", resp_cnt, r0);
    chk("flush_no_write", wr_cnt, w0);
    chk("flush_mtvec", mtvec, 32'h80001000);

    r0 = redir_cnt; d0 = ecall_cnt;
    send(3'd3, 12'h0, 32'h0, 1'b0, 32'h80000080, 32'h0B);
    @(negedge clk);
    chk("rst_trap_pre", {31'h0, ecall_en}, 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("rst_trap_async", {31'h0, ecall_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_trap_no_redir", redir_cnt, r0);
    chk("rst_trap_no_commit", ecall_cnt, d0);
    chk("rst_trap_mepc", mepc, 32'h80000040);

    w0 = wr_cnt; d0 = ecall_cnt;
    send(3'd6, 12'h300, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("illegal_resp", {30'h0, resp_valid, resp_illegal}, 32'h3);
    chk("illegal_strobes", {29'h0, wr_en_csr, ecall_en, redirect_valid}, 32'h0);
    @(negedge clk);
    chk("illegal_ready", {31'h0, req_ready}, 32'h1);
    chk("illegal_no_write", wr_cnt, w0);
    chk("illegal_no_ecall", ecall_cnt, d0);
    chk("illegal_mstatus", mstatus, 32'h1800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
